// File: rtl/fwd_hazard_unit_pkg.sv
// fwd_hazard_unit_pkg: opcodes, forwarding encoding and pipeline stage record
package fwd_hazard_unit_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_RED, OP_XOR, OP_SLL, OP_SRA, OP_ROR, OP_PADDSB,
    OP_LW, OP_SW, OP_LHB, OP_LLB, OP_B, OP_BR, OP_PCS, OP_HLT
  } opcode_e;
  typedef enum logic [1:0] {FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_e;
  typedef struct packed {
    logic       valid;
    logic       wr;
    logic [3:0] dest;
    logic [3:0] src_a;
    logic       used_a;
    logic [3:0] src_b;
    logic       used_b;
    logic       is_lw;
    logic       is_hlt;
  } stage_t;
  // the EX/MEM producer is younger than MEM/WB, so it is tested first
  function automatic fwd_e fwd_sel(input logic used, input logic [3:0] src,
                                   input stage_t mem, input stage_t wb);
    return (used && mem.valid && mem.wr && mem.dest == src) ? FWD_MEM :
           (used && wb.valid && wb.wr && wb.dest == src) ? FWD_WB : FWD_REG;
  endfunction
endpackage

// File: rtl/fwd_hazard_unit_regdecode.sv
// instr_regdecode: register usage of one instruction
module instr_regdecode
  import fwd_hazard_unit_pkg::*;
(
  input  logic [15:0] instr_i,
  output stage_t      dec_o
);
  opcode_e op;
  assign op = opcode_e'(instr_i[15:12]);
  always_comb begin
    dec_o        = '0;
    dec_o.valid  = 1'b1;
    dec_o.dest   = instr_i[11:8];
    dec_o.wr     = (op <= OP_LW || op == OP_LHB || op == OP_LLB || op == OP_PCS) && instr_i[11:8] != 4'd0;
    dec_o.used_a = op <= OP_SW || op == OP_BR || op == OP_LHB || op == OP_LLB;
    dec_o.src_a  = (op == OP_LHB || op == OP_LLB) ? instr_i[11:8] : instr_i[7:4];
    dec_o.used_b = op <= OP_XOR || op == OP_PADDSB || op == OP_SW;
    dec_o.src_b  = (op == OP_SW) ? instr_i[11:8] : instr_i[3:0];
    dec_o.is_lw  = op == OP_LW;
    dec_o.is_hlt = op == OP_HLT;
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding, load-use stall and halt tracking
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id_instr,
  input  logic        id_valid,
  input  logic        flush,
  input  logic        mem_busy,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic        stall,
  output logic        halted
);
  stage_t id_dec, idex_d, idex_q, exmem_q, memwb_q;
  logic   load_use, hlt_seen_q, halted_q;
  instr_regdecode u_dec (.instr_i(id_instr), .dec_o(id_dec));
  always_comb begin
    load_use = idex_q.valid && idex_q.is_lw && idex_q.wr && id_valid &&
               ((id_dec.used_a && id_dec.src_a == idex_q.dest) ||
                (id_dec.used_b && id_dec.src_b == idex_q.dest));
    stall    = mem_busy || (load_use && !flush);
    // bubbles are stored all-zero so stale fields can never match
    idex_d   = (id_valid && !flush && !stall && !hlt_seen_q) ? id_dec : '0;
    ForwardA = fwd_sel(idex_q.used_a, idex_q.src_a, exmem_q, memwb_q);
    ForwardB = fwd_sel(idex_q.used_b, idex_q.src_b, exmem_q, memwb_q);
    halted   = halted_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q     <= '0;
      exmem_q    <= '0;
      memwb_q    <= '0;
      hlt_seen_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      if (!mem_busy) begin
        idex_q     <= idex_d;
        exmem_q    <= idex_q;
        memwb_q    <= exmem_q;
        hlt_seen_q <= hlt_seen_q | idex_d.is_hlt;
      end
      halted_q <= halted_q | (memwb_q.valid & memwb_q.is_hlt);
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: scoreboard-driven scenario checks of fwd_hazard_unit
module tb_fwd_hazard_unit;
  typedef struct packed {
    logic [15:0] i;
    logic        v, fl, mb, r;
    logic [5:0]  e;
  } step_t;
  logic        clk = 1'b0, rst = 1'b1, id_valid = 1'b0, flush = 1'b0, mem_busy = 1'b0;
  logic [15:0] id_instr = 16'h0;
  logic [1:0]  fa, fb;
  logic        st, hl;
  logic [5:0]  sb[$];
  int          n_run = 0, n_fail = 0;
  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .flush(flush),
    .mem_busy(mem_busy), .ForwardA(fa), .ForwardB(fb), .stall(st), .halted(hl)
  );
  always #5 clk = ~clk;
  function automatic step_t mk(input logic [15:0] i, input logic v, fl, mb, r, input logic [5:0] e);
    return '{i, v, fl, mb, r, e};
  endfunction
  function automatic step_t iss(input logic [15:0] i, input logic [5:0] e);
    return mk(i, 1'b1, 1'b0, 1'b0, 1'b0, e);
  endfunction
  function automatic step_t bub(input logic [5:0] e);
    return mk(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, e);
  endfunction
  // expectation layout: {ForwardA, ForwardB, stall, halted}
  task automatic apply(input step_t s);
    @(posedge clk);
    #1;
    id_instr = s.i; id_valid = s.v; flush = s.fl; mem_busy = s.mb; rst = s.r;
    sb.push_back(s.e);
    @(negedge clk);
  endtask
  task automatic test_reset();
    step_t s [2] = '{bub(6'b0), bub(6'b0)};
    logic [5:0] e;
    foreach (s[k]) begin
      apply(s[k]); e = sb.pop_front(); n_run++;
      if ({fa, fb, st, hl} !== e) begin n_fail++; $display("FAIL reset[%0d]: got %b want %b", k, {fa, fb, st, hl}, e); end
    end
  endtask
  task automatic test_fwd_mem();
    step_t s [6] = '{iss(16'h0123, 6'b0), iss(16'h1415, 6'b0), bub(6'b10_00_0_0),
                     bub(6'b0), bub(6'b0), bub(6'b0)};
    logic [5:0] e;
    foreach (s[k]) begin
      apply(s[k]); e = sb.pop_front(); n_run++;
      if ({fa, fb, st, hl} !== e) begin n_fail++; $display("FAIL fwd_mem[%0d]: got %b want %b", k, {fa, fb, st, hl}, e); end
    end
  endtask
  task automatic test_fwd_wb();
    step_t s [7] = '{iss(16'h0123, 6'b0), bub(6'b0), iss(16'h3671, 6'b0), bub(6'b00_01_0_0),
                     bub(6'b0), bub(6'b0), bub(6'b0)};
    logic [5:0] e;
    foreach (s[k]) begin
      apply(s[k]); e = sb.pop_front(); n_run++;
      if ({fa, fb, st, hl} !== e) begin n_fail++; $display("FAIL fwd_wb[%0d]: got %b want %b", k, {fa, fb, st, hl}, e); end
    end
  endtask
  task automatic test_load_use();
    step_t s [7] = '{iss(16'h8230, 6'b0), iss(16'h0422, 6'b00_00_1_0), iss(16'h0422, 6'b0),
                     bub(6'b01_01_0_0), bub(6'b0), bub(6'b0), bub(6'b0)};
    logic [5:0] e;
    foreach (s[k]) begin
      apply(s[k]); e = sb.pop_front(); n_run++;
      if ({fa, fb, st, hl} !== e) begin n_fail++; $display("FAIL load_use[%0d]: got %b want %b", k, {fa, fb, st, hl}, e); end
    end
  endtask
  task automatic test_flush_load_use();
    step_t s [6] = '{iss(16'h8230, 6'b0), mk(16'h0422, 1'b1, 1'b1, 1'b0, 1'b0, 6'b0),
                     bub(6'b0), bub(6'b0), bub(6'b0), bub(6'b0)};
    logic [5:0] e;
    foreach (s[k]) begin
      apply(s[k]); e = sb.pop_front(); n_run++;
      if ({fa, fb, st, hl} !== e) begin n_fail++; $display("FAIL flush_load_use[%0d]: got %b want %b", k, {fa, fb, st, hl}, e); end
    end
  endtask
  task automatic test_youngest();
    step_t s [14] = '{iss(16'h0123, 6'b0), iss(16'h0145, 6'b0), iss(16'h0811, 6'b0),
                      bub(6'b10_10_0_0), bub(6'b0), bub(6'b0), bub(6'b0),
                      iss(16'h0023, 6'b0), iss(16'h0045, 6'b0), iss(16'h0800, 6'b0),
                      bub(6'b0), bub(6'b0), bub(6'b0), bub(6'b0)};
    logic [5:0] e;
    foreach (s[k]) begin
      apply(s[k]); e = sb.pop_front(); n_run++;
      if ({fa, fb, st, hl} !== e) begin n_fail++; $display("FAIL youngest[%0d]: got %b want %b", k, {fa, fb, st, hl}, e); end
    end
  endtask
  task automatic test_mem_busy();
    step_t s [10] = '{iss(16'h0123, 6'b0), iss(16'h1415, 6'b0),
                      mk(16'h0911, 1'b1, 1'b1, 1'b1, 1'b0, 6'b10_00_1_0),
                      mk(16'h0911, 1'b1, 1'b0, 1'b1, 1'b0, 6'b10_00_1_0),
                      mk(16'h0911, 1'b1, 1'b0, 1'b1, 1'b0, 6'b10_00_1_0),
                      iss(16'h0911, 6'b10_00_0_0), bub(6'b01_01_0_0),
                      bub(6'b0), bub(6'b0), bub(6'b0)};
    logic [5:0] e;
    foreach (s[k]) begin
      apply(s[k]); e = sb.pop_front(); n_run++;
      if ({fa, fb, st, hl} !== e) begin n_fail++; $display("FAIL mem_busy[%0d]: got %b want %b", k, {fa, fb, st, hl}, e); end
    end
  endtask
  task automatic test_halt();
    step_t s [8] = '{iss(16'hF000, 6'b0), iss(16'h0123, 6'b0), iss(16'h0511, 6'b0),
                     iss(16'h0511, 6'b0), iss(16'h0511, 6'b00_00_0_1), iss(16'h0511, 6'b00_00_0_1),
                     mk(16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b00_00_0_1), bub(6'b0)};
    logic [5:0] e;
    foreach (s[k]) begin
      apply(s[k]); e = sb.pop_front(); n_run++;
      if ({fa, fb, st, hl} !== e) begin n_fail++; $display("FAIL halt[%0d]: got %b want %b", k, {fa, fb, st, hl}, e); end
    end
  endtask
  task automatic test_reset_mid();
    step_t s [6] = '{iss(16'h0123, 6'b0), mk(16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b0),
                     iss(16'h1415, 6'b0), bub(6'b0), bub(6'b0), bub(6'b0)};
    logic [5:0] e;
    foreach (s[k]) begin
      apply(s[k]); e = sb.pop_front(); n_run++;
      if ({fa, fb, st, hl} !== e) begin n_fail++; $display("FAIL reset_mid[%0d]: got %b want %b", k, {fa, fb, st, hl}, e); end
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_fwd_mem();
    test_fwd_wb();
    test_load_use();
    test_flush_load_use();
    test_youngest();
    test_mem_busy();
    test_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 id_instr  input  16  instruction currently in ID.
REQ-004 id_valid  input  1  ID holds a real instruction (0 = bubble).
REQ-005 flush  input  1  taken branch resolved this cycle; squash the IF/ID instruction.
REQ-006 mem_busy  input  1  memory stall; freeze every pipeline stage.
REQ-007 ForwardA  output  2  EX operand-A select: 10 alu_out_MEM, 01 WriteData, 00 register file.
REQ-008 ForwardB  output  2  EX operand-B select, same encoding as ForwardA.
REQ-009 stall  output  1  hold PC and IF/ID, inject bubble into ID/EX.
REQ-010 halted  output  1  hlt has retired from WB; sticky.

Function
REQ-011 Opcodes are id_instr[15:12]: 0000 add, 0001 sub, 0010 red, 0011 xor, 0100 sll, 0101 sra, 0110 ror, 0111 paddsb, 1000 lw, 1001 sw, 1010 lhb, 1011 llb, 1100 b, 1101 br, 1110 pcs, 1111 hlt.
REQ-012 Register writers: 0000-1000, 1010, 1011, 1110; dest = [11:8]; a write to register 0 is treated as non-writing.
REQ-013 Source A: [7:4] for 0000-1001 and 1101; [11:8] for 1010/1011; none otherwise.
REQ-014 Source B: [3:0] for 0000-0011 and 0111; [11:8] for 1001 (store data); none otherwise.
REQ-015 Decoded fields are tracked in three internal stage registers: IDEX, EXMEM, MEMWB. Each stage holds valid, wr, dest[3:0], srcA/srcB plus their used flags, is_lw and is_hlt.
REQ-016 Normal cycle: MEMWB<=EXMEM, EXMEM<=IDEX, IDEX<=decode(id_instr). The IDEX entry is invalid when id_valid=0, flush=1 or stall=1.
REQ-017 mem_busy=1 holds all three stage registers unchanged and forces stall=1; it takes priority over flush.
REQ-018 ForwardA[1] = IDEX.srcA used, EXMEM valid and wr, and dest equal to IDEX.srcA.
REQ-019 ForwardA[0] = not ForwardA[1], with the same match test against MEMWB.
REQ-020 ForwardB follows REQ-018/REQ-019 using srcB; both are combinational from the stage registers.
REQ-021 A simultaneous EXMEM and MEMWB match SHALL yield 10 (youngest wins); 11 is never driven.
REQ-022 Load-use stall: stall=1 when IDEX is a valid lw and its dest matches a used source of the decoded ID instruction (id_valid=1). The stall lasts exactly one cycle per hazard.
REQ-023 A flush in the same cycle as a load-use hazard gives stall=0, and the bubble is inserted by the squash.
REQ-024 An hlt in ID stops further decode: every later IDEX entry is invalid until reset. The hlt itself propagates through the stages.
REQ-025 halted rises in the cycle after the hlt entry occupies MEMWB, and stays 1 until rst.
REQ-026 Latency: decode to IDEX takes 1 cycle; forwarding selects are valid in the same cycle the consumer occupies IDEX.

Reset
REQ-027 With rst=1 at a clock edge, all stage valid bits clear, the halt latch clears, and the hlt-seen flag clears.
REQ-028 While stage registers are invalid, ForwardA=00, ForwardB=00, stall=0, halted=0.
REQ-029 rst mid-stall or mid-halt drops all in-flight entries; no forwarding results from pre-reset instructions.

Structure
REQ-030 Opcode constants, the forward encoding (FWD_REG=00, FWD_WB=01, FWD_MEM=10) and the stage-record typedef belong in the shared CPU package, shared with the ALU control.
REQ-031 One sub-module, instr_regdecode, maps an instruction to {wr, dest, srcA, usedA, srcB, usedB, is_lw, is_hlt}. It is instantiated once, for ID.

Verification
REQ-032 Run add r1,r2,r3 then sub r4,r1,r5 back-to-back -> while sub is in EX, ForwardA=10 and ForwardB=00.
REQ-033 Run add r1,.. ; nop ; xor r6,r7,r1 -> when xor is in EX, ForwardB=01.
REQ-034 Run lw r2,0(r3) then add r4,r2,r2 -> stall=1 for exactly one cycle; add then enters EX with ForwardA=01 and ForwardB=01.
REQ-035 Run add r1,..; add r1,..; add r8,r1,r1 -> ForwardA=10, never 11. Repeat with dest r0 -> ForwardA=00.
REQ-036 Assert mem_busy for 3 cycles during the REQ-032 sequence -> stage contents are frozen and the forwarding result after release is the same as without the stall.
REQ-037 Issue hlt followed by add -> the add never enters IDEX; halted=1 four cycles after hlt is in ID; rst clears halted to 0.
